// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM and the ALU control decoder.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_source;
    } ctrl_word_t;

endpackage

// File: rtl/control_word_decode.sv
// Purely combinational Moore map from FSM state to the datapath control word.
module control_word_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    output ctrl_word_t o_cw
);

    always_comb begin
        o_cw = '0;
        case (i_state)
            S_FETCH: begin
                // ir_write/pc_write are qualified by mem_ready in the top
                o_cw.mem_read  = 1'b1;
                o_cw.ir_write  = 1'b1;
                o_cw.pc_write  = 1'b1;
                o_cw.alu_src_b = SRCB_FOUR;
                o_cw.alu_op    = ALUOP_ADD;
                o_cw.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                o_cw.alu_src_b = SRCB_IMMSL2;
                o_cw.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_IMM;
                o_cw.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_cw.mem_read = 1'b1;
                o_cw.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_cw.mem_write = 1'b1;
                o_cw.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRCB_B;
                o_cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_cw.reg_write = 1'b1;
                o_cw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_cw.alu_src_a     = 1'b1;
                o_cw.alu_src_b     = SRCB_B;
                o_cw.alu_op        = ALUOP_SUB;
                o_cw.pc_write_cond = 1'b1;
                o_cw.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_cw.pc_write  = 1'b1;
                o_cw.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                o_cw.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state sequencing, fetch-stage
// mem_ready qualification and the sticky illegal-opcode flag.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op
);

    state_t     r_state;
    logic       r_illegal;
    ctrl_word_t w_cw;
    logic       w_fetch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default: begin
                            r_state   <= S_FETCH;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                // opcode is re-sampled here to pick the load or store path
                S_MEMADR: begin
                    if (opcode == OP_SW)      r_state <= S_MEMWR;
                    else if (opcode == OP_LW) r_state <= S_MEMRD;
                    else                      r_state <= S_FETCH;
                end
                S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    control_word_decode u_decode (
        .i_state (r_state),
        .o_cw    (w_cw)
    );

    // Fetch only commits IR/PC once memory has delivered the instruction
    assign w_fetch_ok = (r_state != S_FETCH) || mem_ready;

    assign pc_write      = w_cw.pc_write & w_fetch_ok;
    assign ir_write      = w_cw.ir_write & w_fetch_ok;
    assign pc_write_cond = w_cw.pc_write_cond;
    assign i_or_d        = w_cw.i_or_d;
    assign mem_read      = w_cw.mem_read;
    assign mem_write     = w_cw.mem_write;
    assign mem_to_reg    = w_cw.mem_to_reg;
    assign reg_dst       = w_cw.reg_dst;
    assign reg_write     = w_cw.reg_write;
    assign alu_src_a     = w_cw.alu_src_a;
    assign alu_src_b     = w_cw.alu_src_b;
    assign alu_op        = w_cw.alu_op;
    assign pc_source     = w_cw.pc_source;
    assign illegal_op    = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: expected control vectors are
// pushed per cycle from an independent state table and popped at the falling edge.
module tb_multicycle_control;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMRD = 4,
                   ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                   ST_JUMP = 10, ST_ADDIEX = 11, ST_ADDIWB = 12;

    localparam logic [5:0] C_RT = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                           C_BEQ = 6'b000100, C_J = 6'b000010, C_ADDI = 6'b001000,
                           C_BAD = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    logic [16:0] obs;
    logic [16:0] exp_q[$];
    logic        exp_ill;
    int          n_pass;
    int          n_total;

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op};

    // Expected outputs for a state, written straight from the state table
    function automatic logic [16:0] exp_vec(input int st, input logic mr, input logic ill);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
        logic [1:0] sb, op, ps;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = 10'b0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            ST_FETCH:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
            ST_DECODE: sb = 2'b11;
            ST_MEMADR: begin sa = 1'b1; sb = 2'b10; end
            ST_MEMRD:  begin mrd = 1'b1; iod = 1'b1; end
            ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            ST_MEMWR:  begin mwr = 1'b1; iod = 1'b1; end
            ST_EXEC:   begin sa = 1'b1; op = 2'b10; end
            ST_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
            ST_BRANCH: begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
            ST_JUMP:   begin pw = 1'b1; ps = 2'b10; end
            ST_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
            ST_ADDIWB: rw = 1'b1;
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, op, ps, ill};
    endfunction

    task automatic compare(input string tag);
        logic [16:0] e;
        e = exp_q.pop_front();
        n_total++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, e);
    endtask

    // One clock: drive inputs, queue expectation, check at negedge, advance past posedge
    task automatic cyc(input logic mr, input logic [5:0] op, input int st, input string tag);
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back(exp_vec(st, mr, exp_ill));
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input int st, input string tag);
        exp_q.push_back(exp_vec(st, mem_ready, exp_ill));
        compare(tag);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        exp_ill   = 1'b0;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = C_RT;
        #2;
        check_now(ST_IDLE, "reset_idle");
        @(posedge clk);
        #1;
        check_now(ST_IDLE, "reset_held");
        rst_n = 1'b1;

        // R-type straight out of reset
        cyc(1'b1, C_RT, ST_IDLE,   "rt_idle");
        cyc(1'b1, C_RT, ST_FETCH,  "rt_fetch");
        cyc(1'b1, C_RT, ST_DECODE, "rt_decode");
        cyc(1'b1, C_LW, ST_EXEC,   "rt_exec");
        cyc(1'b0, C_LW, ST_ALUWB,  "rt_aluwb");

        // lw with two memory stall cycles
        cyc(1'b1, C_LW, ST_FETCH,  "lw_fetch");
        cyc(1'b1, C_LW, ST_DECODE, "lw_decode");
        cyc(1'b1, C_LW, ST_MEMADR, "lw_memadr");
        cyc(1'b0, C_RT, ST_MEMRD,  "lw_memrd0");
        cyc(1'b0, C_RT, ST_MEMRD,  "lw_memrd1");
        cyc(1'b1, C_RT, ST_MEMRD,  "lw_memrd2");
        cyc(1'b1, C_RT, ST_MEMWB,  "lw_memwb");

        // fetch stall then beq
        cyc(1'b0, C_BEQ, ST_FETCH,  "stall_fetch0");
        cyc(1'b0, C_BEQ, ST_FETCH,  "stall_fetch1");
        cyc(1'b0, C_BEQ, ST_FETCH,  "stall_fetch2");
        cyc(1'b1, C_BEQ, ST_FETCH,  "stall_fetch_go");
        cyc(1'b1, C_BEQ, ST_DECODE, "beq_decode");
        cyc(1'b1, C_BAD, ST_BRANCH, "beq_branch");

        // jump
        cyc(1'b1, C_J, ST_FETCH,  "j_fetch");
        cyc(1'b1, C_J, ST_DECODE, "j_decode");
        cyc(1'b0, C_J, ST_JUMP,   "j_jump");

        // illegal opcode, then addi keeps decoding with the flag held
        cyc(1'b1, C_BAD, ST_FETCH,  "bad_fetch");
        cyc(1'b1, C_BAD, ST_DECODE, "bad_decode");
        exp_ill = 1'b1;
        cyc(1'b1, C_ADDI, ST_FETCH,  "addi_fetch");
        cyc(1'b1, C_ADDI, ST_DECODE, "addi_decode");
        cyc(1'b1, C_RT,   ST_ADDIEX, "addi_ex");
        cyc(1'b0, C_RT,   ST_ADDIWB, "addi_wb");

        // sw interrupted by reset mid-write
        cyc(1'b1, C_SW, ST_FETCH,  "sw_fetch");
        cyc(1'b1, C_SW, ST_DECODE, "sw_decode");
        cyc(1'b1, C_SW, ST_MEMADR, "sw_memadr");
        cyc(1'b0, C_SW, ST_MEMWR,  "sw_memwr_stall");
        check_now(ST_MEMWR, "sw_memwr_held");
        rst_n = 1'b0;
        #1;
        exp_ill = 1'b0;
        check_now(ST_IDLE, "rst_mid_idle");
        n_total++;
        assert (mem_write === 1'b0) n_pass++;
        else $error("FAIL rst_mid_mem_write: observed %b expected 0", mem_write);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clean sw after reset
        cyc(1'b1, C_SW, ST_FETCH,  "sw2_fetch");
        cyc(1'b1, C_SW, ST_DECODE, "sw2_decode");
        cyc(1'b1, C_SW, ST_MEMADR, "sw2_memadr");
        cyc(1'b1, C_SW, ST_MEMWR,  "sw2_memwr");
        cyc(1'b1, C_RT, ST_FETCH,  "sw2_back_fetch");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
